// File: rtl/algo_nru_err_wrap.sv
// rtl/algo_nru_err_wrap.sv - N-read-port error masking, counting and first-error logging wrapper
module algo_nru_err_wrap #(
    parameter int NUMRUPT = 2,
    parameter int WIDTH   = 32,
    parameter int BITPADR = 16,
    parameter int CNTWDTH = 8,
    parameter int FLOPOUT = 0,
    localparam int LPW    = (NUMRUPT > 1) ? $clog2(NUMRUPT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       core_ready,
    input  logic [NUMRUPT-1:0]         core_vld,
    input  logic [NUMRUPT*WIDTH-1:0]   core_dout,
    input  logic [NUMRUPT-1:0]         core_serr,
    input  logic [NUMRUPT-1:0]         core_derr,
    input  logic [NUMRUPT*BITPADR-1:0] core_padr,
    output logic                       ready,
    output logic [NUMRUPT-1:0]         ru_vld,
    output logic [NUMRUPT*WIDTH-1:0]   ru_dout,
    output logic [NUMRUPT-1:0]         ru_serr,
    output logic [NUMRUPT-1:0]         ru_derr,
    output logic [NUMRUPT*BITPADR-1:0] ru_padr,
    input  logic                       cnt_clr,
    output logic [NUMRUPT*CNTWDTH-1:0] serr_cnt,
    output logic [NUMRUPT*CNTWDTH-1:0] derr_cnt,
    input  logic                       log_clr,
    output logic                       log_vld,
    output logic [LPW-1:0]             log_port,
    output logic                       log_derr,
    output logic [BITPADR-1:0]         log_padr,
    output logic                       err_int
);

    typedef enum logic {LOG_EMPTY, LOG_HELD} log_state_e;

    logic [NUMRUPT-1:0] m_serr;
    logic [NUMRUPT-1:0] m_derr;

    // Reads that land in the spare/parity region (padr MSB set) never report errors.
    always_comb begin
        m_serr = '0;
        m_derr = '0;
        for (int p = 0; p < NUMRUPT; p++) begin
            m_derr[p] = core_vld[p] & ~core_padr[p*BITPADR + BITPADR-1] & core_derr[p];
            m_serr[p] = core_vld[p] & ~core_padr[p*BITPADR + BITPADR-1] & core_serr[p] & ~core_derr[p];
        end
    end

    logic ready_q, ready_d;
    assign ready_d = core_ready;
    assign ready   = ready_q;

    // Error counters, sampled at the core side regardless of output flopping.
    logic [CNTWDTH-1:0] serr_cnt_q [NUMRUPT];
    logic [CNTWDTH-1:0] serr_cnt_d [NUMRUPT];
    logic [CNTWDTH-1:0] derr_cnt_q [NUMRUPT];
    logic [CNTWDTH-1:0] derr_cnt_d [NUMRUPT];

    always_comb begin
        for (int p = 0; p < NUMRUPT; p++) begin
            serr_cnt_d[p] = serr_cnt_q[p];
            derr_cnt_d[p] = derr_cnt_q[p];
            if (cnt_clr) begin
                serr_cnt_d[p] = '0;
                derr_cnt_d[p] = '0;
            end else begin
                if (m_serr[p] && (serr_cnt_q[p] != {CNTWDTH{1'b1}}))
                    serr_cnt_d[p] = serr_cnt_q[p] + 1'b1;
                if (m_derr[p] && (derr_cnt_q[p] != {CNTWDTH{1'b1}}))
                    derr_cnt_d[p] = derr_cnt_q[p] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUMRUPT; g++) begin : g_cnt_out
        assign serr_cnt[g*CNTWDTH +: CNTWDTH] = serr_cnt_q[g];
        assign derr_cnt[g*CNTWDTH +: CNTWDTH] = derr_cnt_q[g];
    end

    // First-error candidate: any derr beats any serr, then the lowest port wins.
    logic               sel_found;
    logic [LPW-1:0]     sel_port;
    logic               sel_derr;
    logic [BITPADR-1:0] sel_padr;

    always_comb begin
        sel_found = 1'b0;
        sel_port  = '0;
        sel_derr  = 1'b0;
        sel_padr  = '0;
        for (int p = 0; p < NUMRUPT; p++) begin
            if (!sel_found && m_derr[p]) begin
                sel_found = 1'b1;
                sel_port  = LPW'(p);
                sel_derr  = 1'b1;
                sel_padr  = core_padr[p*BITPADR +: BITPADR];
            end
        end
        for (int p = 0; p < NUMRUPT; p++) begin
            if (!sel_found && m_serr[p]) begin
                sel_found = 1'b1;
                sel_port  = LPW'(p);
                sel_derr  = 1'b0;
                sel_padr  = core_padr[p*BITPADR +: BITPADR];
            end
        end
    end

    log_state_e         state_q, state_d;
    logic [LPW-1:0]     log_port_q, log_port_d;
    logic               log_derr_q, log_derr_d;
    logic [BITPADR-1:0] log_padr_q, log_padr_d;
    logic               err_int_q, err_int_d;

    always_comb begin
        state_d    = state_q;
        log_port_d = log_port_q;
        log_derr_d = log_derr_q;
        log_padr_d = log_padr_q;
        case (state_q)
            LOG_EMPTY: begin
                if (sel_found) begin
                    state_d    = LOG_HELD;
                    log_port_d = sel_port;
                    log_derr_d = sel_derr;
                    log_padr_d = sel_padr;
                end
            end
            LOG_HELD: begin
                // A clear coinciding with a new error re-arms and captures at once.
                if (log_clr) begin
                    if (sel_found) begin
                        log_port_d = sel_port;
                        log_derr_d = sel_derr;
                        log_padr_d = sel_padr;
                    end else begin
                        state_d    = LOG_EMPTY;
                        log_port_d = '0;
                        log_derr_d = 1'b0;
                        log_padr_d = '0;
                    end
                end
            end
            default: state_d = LOG_EMPTY;
        endcase
        err_int_d = (state_d == LOG_HELD);
    end

    assign log_vld  = (state_q == LOG_HELD);
    assign log_port = log_port_q;
    assign log_derr = log_derr_q;
    assign log_padr = log_padr_q;
    assign err_int  = err_int_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q    <= 1'b0;
            serr_cnt_q <= '{default: '0};
            derr_cnt_q <= '{default: '0};
            state_q    <= LOG_EMPTY;
            log_port_q <= '0;
            log_derr_q <= 1'b0;
            log_padr_q <= '0;
            err_int_q  <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            serr_cnt_q <= serr_cnt_d;
            derr_cnt_q <= derr_cnt_d;
            state_q    <= state_d;
            log_port_q <= log_port_d;
            log_derr_q <= log_derr_d;
            log_padr_q <= log_padr_d;
            err_int_q  <= err_int_d;
        end
    end

    if (FLOPOUT != 0) begin : g_flop
        logic [NUMRUPT-1:0]         vld_q, vld_d;
        logic [NUMRUPT-1:0]         serr_q, serr_d;
        logic [NUMRUPT-1:0]         derr_q, derr_d;
        logic [NUMRUPT*WIDTH-1:0]   dout_q, dout_d;
        logic [NUMRUPT*BITPADR-1:0] padr_q, padr_d;

        // Data and address hold between valid reads; strobes refresh every cycle.
        always_comb begin
            vld_d  = core_vld;
            serr_d = m_serr;
            derr_d = m_derr;
            dout_d = dout_q;
            padr_d = padr_q;
            for (int p = 0; p < NUMRUPT; p++) begin
                if (core_vld[p]) begin
                    dout_d[p*WIDTH +: WIDTH]     = core_dout[p*WIDTH +: WIDTH];
                    padr_d[p*BITPADR +: BITPADR] = core_padr[p*BITPADR +: BITPADR];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_q  <= '0;
                serr_q <= '0;
                derr_q <= '0;
                dout_q <= '0;
                padr_q <= '0;
            end else begin
                vld_q  <= vld_d;
                serr_q <= serr_d;
                derr_q <= derr_d;
                dout_q <= dout_d;
                padr_q <= padr_d;
            end
        end

        assign ru_vld  = vld_q;
        assign ru_serr = serr_q;
        assign ru_derr = derr_q;
        assign ru_dout = dout_q;
        assign ru_padr = padr_q;
    end else begin : g_comb
        // Outputs are forced low while reset is held so nothing leaks to the user.
        assign ru_vld  = rst ? core_vld  : '0;
        assign ru_serr = rst ? m_serr    : '0;
        assign ru_derr = rst ? m_derr    : '0;
        assign ru_dout = rst ? core_dout : '0;
        assign ru_padr = rst ? core_padr : '0;
    end

endmodule

// File: tb/tb_algo_nru_err_wrap.sv
// tb/tb_algo_nru_err_wrap.sv - directed self-checking bench for algo_nru_err_wrap
module tb_algo_nru_err_wrap;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // dut0: 2 ports, combinational outputs, 4-bit counters
    logic        rst, core_ready, cnt_clr, log_clr;
    logic [1:0]  core_vld, core_serr, core_derr;
    logic [63:0] core_dout;
    logic [31:0] core_padr;
    logic        ready, log_vld, log_derr, err_int;
    logic [1:0]  ru_vld, ru_serr, ru_derr;
    logic [63:0] ru_dout;
    logic [31:0] ru_padr;
    logic [7:0]  serr_cnt, derr_cnt;
    logic [0:0]  log_port;
    logic [15:0] log_padr;

    // dut1: 4 ports, flopped outputs
    logic         f_rst, f_core_ready, f_cnt_clr, f_log_clr;
    logic [3:0]   f_core_vld, f_core_serr, f_core_derr;
    logic [127:0] f_core_dout;
    logic [63:0]  f_core_padr;
    logic         f_ready, f_log_vld, f_log_derr, f_err_int;
    logic [3:0]   f_ru_vld, f_ru_serr, f_ru_derr;
    logic [127:0] f_ru_dout;
    logic [63:0]  f_ru_padr;
    logic [31:0]  f_serr_cnt, f_derr_cnt;
    logic [1:0]   f_log_port;
    logic [15:0]  f_log_padr;

    algo_nru_err_wrap #(.NUMRUPT(2), .WIDTH(32), .BITPADR(16), .CNTWDTH(4), .FLOPOUT(0)) dut0 (
        .clk(clk), .rst(rst), .core_ready(core_ready), .core_vld(core_vld), .core_dout(core_dout),
        .core_serr(core_serr), .core_derr(core_derr), .core_padr(core_padr), .ready(ready),
        .ru_vld(ru_vld), .ru_dout(ru_dout), .ru_serr(ru_serr), .ru_derr(ru_derr), .ru_padr(ru_padr),
        .cnt_clr(cnt_clr), .serr_cnt(serr_cnt), .derr_cnt(derr_cnt), .log_clr(log_clr),
        .log_vld(log_vld), .log_port(log_port), .log_derr(log_derr), .log_padr(log_padr),
        .err_int(err_int)
    );

    algo_nru_err_wrap #(.NUMRUPT(4), .WIDTH(32), .BITPADR(16), .CNTWDTH(8), .FLOPOUT(1)) dut1 (
        .clk(clk), .rst(f_rst), .core_ready(f_core_ready), .core_vld(f_core_vld), .core_dout(f_core_dout),
        .core_serr(f_core_serr), .core_derr(f_core_derr), .core_padr(f_core_padr), .ready(f_ready),
        .ru_vld(f_ru_vld), .ru_dout(f_ru_dout), .ru_serr(f_ru_serr), .ru_derr(f_ru_derr), .ru_padr(f_ru_padr),
        .cnt_clr(f_cnt_clr), .serr_cnt(f_serr_cnt), .derr_cnt(f_derr_cnt), .log_clr(f_log_clr),
        .log_vld(f_log_vld), .log_port(f_log_port), .log_derr(f_log_derr), .log_padr(f_log_padr),
        .err_int(f_err_int)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_vld = '0; core_serr = '0; core_derr = '0; core_dout = '0; core_padr = '0;
        cnt_clr = 1'b0; log_clr = 1'b0;
        f_core_vld = '0; f_core_serr = '0; f_core_derr = '0; f_core_dout = '0; f_core_padr = '0;
        f_cnt_clr = 1'b0; f_log_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; f_rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            core_ready = 1'($urandom); core_vld = 2'($urandom); core_serr = 2'($urandom);
            core_derr = 2'($urandom); core_dout = {$urandom, $urandom}; core_padr = $urandom;
            cnt_clr = 1'($urandom); log_clr = 1'($urandom);
            f_core_ready = 1'($urandom); f_core_vld = 4'($urandom); f_core_derr = 4'($urandom);
            f_core_serr = 4'($urandom); f_core_dout = {$urandom, $urandom, $urandom, $urandom};
            f_core_padr = {$urandom, $urandom};
            tick();
        end
        core_vld = 2'b11; core_serr = 2'b11; core_dout = 64'hFFFF_FFFF_FFFF_FFFF; core_padr = '0;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %h want 0", ready); end
        n_cmp++; if (ru_vld !== 2'b00) begin n_bad++; $display("FAIL rst_ru_vld: got %h want 0", ru_vld); end
        n_cmp++; if (ru_dout !== 64'h0) begin n_bad++; $display("FAIL rst_ru_dout: got %h want 0", ru_dout); end
        n_cmp++; if ({ru_serr, ru_derr} !== 4'h0) begin n_bad++; $display("FAIL rst_ru_err: got %h want 0", {ru_serr, ru_derr}); end
        n_cmp++; if ({serr_cnt, derr_cnt} !== 16'h0) begin n_bad++; $display("FAIL rst_cnt: got %h want 0", {serr_cnt, derr_cnt}); end
        n_cmp++; if ({log_vld, err_int, log_padr} !== 18'h0) begin n_bad++; $display("FAIL rst_log: got %h want 0", {log_vld, err_int, log_padr}); end
        n_cmp++; if ({f_ru_vld, f_ru_dout} !== 132'h0) begin n_bad++; $display("FAIL rst_f_ru: got %h want 0", {f_ru_vld, f_ru_dout}); end
        rst = 1'b1; f_rst = 1'b1; core_ready = 1'b1; f_core_ready = 1'b1;
        idle();
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ready_early: got %h want 0", ready); end
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_follow: got %h want 1", ready); end
    endtask

    task automatic test_masking();
        log_clr = 1'b1;
        tick();
        n_cmp++; if (log_vld !== 1'b0) begin n_bad++; $display("FAIL clr_empty_noop: got %h want 0", log_vld); end
        idle();
        core_vld = 2'b01; core_serr = 2'b01; core_padr[15:0] = 16'h8004; core_dout[31:0] = 32'h1111_2222;
        #1;
        n_cmp++; if (ru_serr !== 2'b00) begin n_bad++; $display("FAIL mask_spare_serr: got %h want 0", ru_serr); end
        n_cmp++; if (ru_vld !== 2'b01) begin n_bad++; $display("FAIL pass_vld: got %h want 1", ru_vld); end
        n_cmp++; if (ru_dout[31:0] !== 32'h1111_2222) begin n_bad++; $display("FAIL pass_dout: got %h want 11112222", ru_dout[31:0]); end
        n_cmp++; if (ru_padr[15:0] !== 16'h8004) begin n_bad++; $display("FAIL pass_padr: got %h want 8004", ru_padr[15:0]); end
        tick();
        n_cmp++; if (serr_cnt !== 8'h00) begin n_bad++; $display("FAIL mask_spare_cnt: got %h want 0", serr_cnt); end
        n_cmp++; if (log_vld !== 1'b0) begin n_bad++; $display("FAIL mask_spare_log: got %h want 0", log_vld); end
        core_vld = 2'b00; core_padr[15:0] = 16'h0004;
        #1;
        n_cmp++; if (ru_serr !== 2'b00) begin n_bad++; $display("FAIL mask_invalid: got %h want 0", ru_serr); end
        tick();
        n_cmp++; if (serr_cnt !== 8'h00) begin n_bad++; $display("FAIL mask_invalid_cnt: got %h want 0", serr_cnt); end
        core_vld = 2'b01;
        #1;
        n_cmp++; if (ru_serr !== 2'b01) begin n_bad++; $display("FAIL serr_pass: got %h want 1", ru_serr); end
        tick();
        n_cmp++; if (serr_cnt !== 8'h01) begin n_bad++; $display("FAIL serr_cnt0: got %h want 01", serr_cnt); end
        idle();
        log_clr = 1'b1; cnt_clr = 1'b1;
        tick();
        idle();
        n_cmp++; if ({log_vld, err_int, serr_cnt} !== 10'h0) begin n_bad++; $display("FAIL clr_cleanup: got %h want 0", {log_vld, err_int, serr_cnt}); end
    endtask

    task automatic test_priority();
        core_vld = 2'b11; core_serr = 2'b11; core_derr = 2'b10;
        core_padr = {16'h0020, 16'h0010};
        #1;
        n_cmp++; if (ru_serr !== 2'b01) begin n_bad++; $display("FAIL derr_dominates_serr: got %h want 1", ru_serr); end
        n_cmp++; if (ru_derr !== 2'b10) begin n_bad++; $display("FAIL ru_derr: got %h want 2", ru_derr); end
        tick();
        idle();
        n_cmp++; if ({log_vld, log_port, log_derr} !== 3'b111) begin n_bad++; $display("FAIL prio_log: got %b want 111", {log_vld, log_port, log_derr}); end
        n_cmp++; if (log_padr !== 16'h0020) begin n_bad++; $display("FAIL prio_padr: got %h want 0020", log_padr); end
        n_cmp++; if (serr_cnt !== 8'h01) begin n_bad++; $display("FAIL prio_serr_cnt: got %h want 01", serr_cnt); end
        n_cmp++; if (derr_cnt !== 8'h10) begin n_bad++; $display("FAIL prio_derr_cnt: got %h want 10", derr_cnt); end
        n_cmp++; if (err_int !== 1'b1) begin n_bad++; $display("FAIL prio_err_int: got %h want 1", err_int); end
    endtask

    task automatic test_sticky_clear();
        core_vld = 2'b01; core_derr = 2'b01; core_padr[15:0] = 16'h0030;
        tick();
        idle();
        n_cmp++; if ({log_vld, log_port, log_derr, log_padr} !== {3'b111, 16'h0020}) begin n_bad++; $display("FAIL sticky_log: got %h want %h", {log_vld, log_port, log_derr, log_padr}, {3'b111, 16'h0020}); end
        n_cmp++; if (derr_cnt !== 8'h11) begin n_bad++; $display("FAIL sticky_cnt: got %h want 11", derr_cnt); end
        log_clr = 1'b1; core_vld = 2'b10; core_serr = 2'b10; core_padr[31:16] = 16'h0040;
        tick();
        idle();
        n_cmp++; if ({log_vld, log_port, log_derr, log_padr} !== {3'b110, 16'h0040}) begin n_bad++; $display("FAIL clr_capture: got %h want %h", {log_vld, log_port, log_derr, log_padr}, {3'b110, 16'h0040}); end
        n_cmp++; if (err_int !== 1'b1) begin n_bad++; $display("FAIL clr_capture_int: got %h want 1", err_int); end
        log_clr = 1'b1;
        tick();
        idle();
        n_cmp++; if ({log_vld, err_int} !== 2'b00) begin n_bad++; $display("FAIL clr_release: got %b want 00", {log_vld, err_int}); end
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 20; i++) begin
            core_vld = 2'b10; core_serr = 2'b10;
            tick();
        end
        idle();
        n_cmp++; if (serr_cnt !== 8'hF0) begin n_bad++; $display("FAIL saturate: got %h want F0", serr_cnt); end
        cnt_clr = 1'b1;
        tick();
        idle();
        n_cmp++; if (serr_cnt !== 8'h00) begin n_bad++; $display("FAIL cnt_clr: got %h want 00", serr_cnt); end
        cnt_clr = 1'b1; core_vld = 2'b10; core_serr = 2'b10;
        tick();
        idle();
        n_cmp++; if (serr_cnt !== 8'h00) begin n_bad++; $display("FAIL cnt_clr_same_cycle: got %h want 00", serr_cnt); end
        core_vld = 2'b10; core_serr = 2'b10;
        tick();
        idle();
        n_cmp++; if (serr_cnt !== 8'h10) begin n_bad++; $display("FAIL cnt_after_clr: got %h want 10", serr_cnt); end
    endtask

    task automatic test_flopout();
        f_core_vld = 4'b1000; f_core_derr = 4'b1000;
        f_core_dout[127:96] = 32'hDEAD_BEEF; f_core_padr[63:48] = 16'h0123;
        #1;
        n_cmp++; if (f_ru_vld !== 4'b0000) begin n_bad++; $display("FAIL flop_early_vld: got %h want 0", f_ru_vld); end
        tick();
        idle();
        f_core_dout[127:96] = 32'h5555_AAAA;
        #1;
        n_cmp++; if (f_ru_vld !== 4'b1000) begin n_bad++; $display("FAIL flop_vld: got %h want 8", f_ru_vld); end
        n_cmp++; if (f_ru_dout[127:96] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL flop_dout: got %h want deadbeef", f_ru_dout[127:96]); end
        n_cmp++; if ({f_ru_derr, f_ru_serr} !== 8'h80) begin n_bad++; $display("FAIL flop_err: got %h want 80", {f_ru_derr, f_ru_serr}); end
        n_cmp++; if (f_ru_padr[63:48] !== 16'h0123) begin n_bad++; $display("FAIL flop_padr: got %h want 0123", f_ru_padr[63:48]); end
        n_cmp++; if ({f_log_vld, f_log_port, f_log_derr, f_derr_cnt[31:24]} !== {4'b1111, 8'h01}) begin n_bad++; $display("FAIL flop_log: got %h want %h", {f_log_vld, f_log_port, f_log_derr, f_derr_cnt[31:24]}, {4'b1111, 8'h01}); end
        tick();
        n_cmp++; if (f_ru_vld !== 4'b0000) begin n_bad++; $display("FAIL flop_vld_drop: got %h want 0", f_ru_vld); end
        n_cmp++; if (f_ru_dout[127:96] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL flop_dout_hold: got %h want deadbeef", f_ru_dout[127:96]); end
        f_core_vld = 4'b1000; f_core_derr = 4'b1000;
        tick();
        n_cmp++; if (f_ru_vld !== 4'b1000) begin n_bad++; $display("FAIL flop_vld2: got %h want 8", f_ru_vld); end
        f_rst = 1'b0;
        tick();
        n_cmp++; if ({f_ru_vld, f_ru_derr} !== 8'h00) begin n_bad++; $display("FAIL flop_rst_drop: got %h want 00", {f_ru_vld, f_ru_derr}); end
        n_cmp++; if ({f_log_vld, f_err_int, f_derr_cnt} !== 34'h0) begin n_bad++; $display("FAIL flop_rst_state: got %h want 0", {f_log_vld, f_err_int, f_derr_cnt}); end
        f_rst = 1'b1;
        idle();
    endtask

    initial begin
        core_ready = 1'b0; f_core_ready = 1'b0;
        test_reset();
        test_masking();
        test_priority();
        test_sticky_clear();
        test_saturation();
        test_flopout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
